tour_cmd_sequencer: RTL and testbench

- Synthesizable command sequencer that sits directly upstream of RemoteComm. It drives RemoteComm's cmd/snd_cmd inputs and consumes its cmd_snt/resp_rdy/resp outputs.
- Replays a queued list of 16-bit Knight commands, e.g. 16'h43F3 = move west 3 squares. An optional gyro-calibration command is issued first.
- Each command is held back until the previous one has been positively acknowledged or has failed.
- Used to run full tours on the FPGA/bench without a host.

---
 rtl/tour_cmd_sequencer_if.sv | 16 +
 rtl/tour_cmd_sequencer.sv | 141 ++++++++++++++
 tb/tb_tour_cmd_sequencer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/tour_cmd_sequencer_if.sv
// tour_cmd_sequencer_if: command/response link between the sequencer and RemoteComm
//   cmd      [15:0] command word presented to RemoteComm
//   snd_cmd         one-cycle request to transmit cmd
//   cmd_snt         RemoteComm finished transmitting cmd
//   resp_rdy        RemoteComm has a response byte
//   resp     [7:0]  response byte
//   master = sequencer side, slave = RemoteComm side
interface tour_cmd_sequencer_if;
   logic [15:0] cmd;
   logic        snd_cmd;
   logic        cmd_snt;
   logic        resp_rdy;
   logic [7:0]  resp;
   modport master (output cmd, snd_cmd, input cmd_snt, resp_rdy, resp);
   modport slave  (input cmd, snd_cmd, output cmd_snt, resp_rdy, resp);
endinterface

// File: rtl/tour_cmd_sequencer.sv
// tour_cmd_sequencer: replays a queued list of Knight commands into RemoteComm
//   clk, rst           clock, synchronous active-high reset
//   i_wr_en, i_wr_cmd  enqueue a command (IDLE/DONE/ERR only)
//   i_clr              empty the queue (IDLE/DONE/ERR only, wins over i_wr_en)
//   i_start, i_cal_en  begin playback, optionally preceded by CAL_CMD
//   i_abort            return to IDLE from any state
//   rc                 RemoteComm link (cmd/snd_cmd out, cmd_snt/resp_rdy/resp in)
//   o_busy/o_done/o_err, o_err_code  status (01 NAK, 10 timeout, 11 overflow)
//   o_cmd_idx          queue commands acknowledged so far
//   o_count            entries currently queued
module tour_cmd_sequencer #(
   parameter int              DEPTH   = 16,
   parameter logic [15:0]     CAL_CMD = 16'h2000,
   parameter logic [7:0]      ACK     = 8'hA5,
   parameter int              TMO_W   = 26,
   parameter logic [TMO_W-1:0] TMO_MAX = 26'h3FF_FFFF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_wr_en,
   input  logic [15:0]               i_wr_cmd,
   input  logic                      i_clr,
   input  logic                      i_start,
   input  logic                      i_cal_en,
   input  logic                      i_abort,
   tour_cmd_sequencer_if.master      rc,
   output logic                      o_busy,
   output logic                      o_done,
   output logic                      o_err,
   output logic [1:0]                o_err_code,
   output logic [$clog2(DEPTH):0]    o_cmd_idx,
   output logic [$clog2(DEPTH):0]    o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT_SNT, S_WAIT_RESP, S_NEXT, S_DONE, S_ERR} state_t;
   state_t           r_state, w_state;
   logic [CW-1:0]    r_count, w_count, r_idx, w_idx;
   logic             r_cal, w_cal;
   logic [TMO_W-1:0] r_tmr, w_tmr;
   logic [15:0]      r_cmd, w_cmd;
   logic             r_snd, w_snd;
   logic [1:0]       r_ecode, w_ecode;
   logic [15:0]      r_q [DEPTH];
   logic             w_idle, w_full, w_wr, w_ack, w_tmo;
   assign w_idle = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR);
   assign w_full = r_count == CW'(DEPTH);
   assign w_wr   = w_idle && i_wr_en && !i_clr && !w_full && !i_abort;
   assign w_ack  = rc.resp_rdy && (rc.resp == ACK);
   // timeout fires on the clock at which the timer would reach TMO_MAX,
   // i.e. TMO_MAX clocks after the cmd_snt edge
   assign w_tmo  = (r_tmr + 1'b1) == TMO_MAX;
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state;
   end
   always_comb begin
      w_state = r_state;
      w_count = r_count;
      w_idx   = r_idx;
      w_cal   = r_cal;
      w_tmr   = r_tmr;
      w_cmd   = r_cmd;
      w_snd   = 1'b0;
      w_ecode = r_ecode;
      if (i_abort) begin
         w_state = S_IDLE;
         w_tmr   = '0;
         w_ecode = 2'b00;
      end else if (w_idle) begin
         w_count = i_clr ? '0 : (w_wr ? r_count + 1'b1 : r_count);
         // decide on the post-write/clear count so a same-cycle clr cannot
         // launch playback of an empty queue
         if (i_start) begin
            w_cal   = i_cal_en;
            w_idx   = '0;
            w_ecode = 2'b00;
            w_state = (i_cal_en || w_count != '0) ? S_SEND : S_DONE;
         end else if (i_wr_en && !i_clr && w_full) begin
            w_state = S_ERR;
            w_ecode = 2'b11;
         end
      end else begin
         case (r_state)
            S_SEND: begin
               // cmd and snd_cmd are registered together so they are seen by RemoteComm in the same cycle
               w_cmd   = r_cal ? CAL_CMD : r_q[r_idx[AW-1:0]];
               w_snd   = 1'b1;
               w_state = S_WAIT_SNT;
            end
            S_WAIT_SNT: begin
               w_tmr   = rc.cmd_snt ? '0 : r_tmr;
               w_state = rc.cmd_snt ? S_WAIT_RESP : S_WAIT_SNT;
            end
            S_WAIT_RESP: begin
               w_tmr = r_tmr + 1'b1;
               if (w_ack) begin
                  w_cal   = 1'b0;
                  w_idx   = (r_cal || r_idx == CW'(DEPTH)) ? r_idx : r_idx + 1'b1;
                  w_state = S_NEXT;
               end else if (rc.resp_rdy || w_tmo) begin
                  w_state = S_ERR;
                  w_ecode = rc.resp_rdy ? 2'b01 : 2'b10;
               end
            end
            S_NEXT:  w_state = (r_idx >= r_count) ? S_DONE : S_SEND;
            default: w_state = S_IDLE;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
         r_idx   <= '0;
         r_cal   <= 1'b0;
         r_tmr   <= '0;
         r_cmd   <= '0;
         r_snd   <= 1'b0;
         r_ecode <= 2'b00;
      end else begin
         r_count <= w_count;
         r_idx   <= w_idx;
         r_cal   <= w_cal;
         r_tmr   <= w_tmr;
         r_cmd   <= w_cmd;
         r_snd   <= w_snd;
         r_ecode <= w_ecode;
      end
   end
   always_ff @(posedge clk) begin
      if (w_wr && !rst) r_q[r_count[AW-1:0]] <= i_wr_cmd;
   end
   assign rc.cmd     = r_cmd;
   assign rc.snd_cmd = r_snd;
   assign o_busy     = !w_idle;
   assign o_done     = r_state == S_DONE;
   assign o_err      = r_state == S_ERR;
   assign o_err_code = r_ecode;
   assign o_cmd_idx  = r_idx;
   assign o_count    = r_count;
endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// tb_tour_cmd_sequencer: vector table, directed corner cases and randomized tours against a command-list model
module tb_tour_cmd_sequencer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_wr_en = 1'b0, i_clr = 1'b0, i_start = 1'b0, i_cal_en = 1'b0, i_abort = 1'b0;
   logic [15:0] i_wr_cmd = '0;
   logic        o_busy, o_done, o_err;
   logic [1:0]  o_err_code;
   logic [4:0]  o_cmd_idx, o_count;
   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] q_model[$];
   logic [15:0] sent[$];
   tour_cmd_sequencer_if bus();
   tour_cmd_sequencer #(.DEPTH(16), .TMO_MAX(26'd100)) dut (
      .clk(clk), .rst(rst), .i_wr_en(i_wr_en), .i_wr_cmd(i_wr_cmd), .i_clr(i_clr),
      .i_start(i_start), .i_cal_en(i_cal_en), .i_abort(i_abort), .rc(bus),
      .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_err_code(o_err_code),
      .o_cmd_idx(o_cmd_idx), .o_count(o_count)
   );
   always #5 clk = ~clk;
   always @(negedge clk) if (bus.snd_cmd === 1'b1) sent.push_back(bus.cmd);
   typedef struct {
      logic wr; logic [15:0] d; logic clr; logic st;
      logic [4:0] cnt; logic done; logic err; logic [1:0] code;
   } vec_t;
   vec_t tv[$];
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic wr(input logic [15:0] d);
      i_wr_en = 1'b1; i_wr_cmd = d; step(); i_wr_en = 1'b0;
      if (q_model.size() < 16) q_model.push_back(d);
   endtask
   task automatic clr();
      i_clr = 1'b1; step(); i_clr = 1'b0;
      q_model.delete();
   endtask
   task automatic wait_snd();
      int g = 0;
      while (bus.snd_cmd !== 1'b1 && g < 20) begin step(); g++; end
      chk("snd_seen", {31'd0, bus.snd_cmd}, 1);
   endtask
   // plays RemoteComm for one tour; nak_at = position in the sent stream that gets a bad response
   task automatic run(input bit cal, input int nak_at, input int rdly);
      logic [15:0] exp_q[$];
      logic [7:0]  nb;
      int k, guard, n0, n_exp, acked;
      bit nak;
      exp_q = {};
      if (cal) exp_q.push_back(16'h2000);
      foreach (q_model[i]) exp_q.push_back(q_model[i]);
      n0 = sent.size();
      i_cal_en = cal; i_start = 1'b1; step(); i_start = 1'b0; i_cal_en = 1'b0;
      k = 0; guard = 0;
      while (guard < 3000 && !(o_done || o_err)) begin
         if (bus.snd_cmd) begin
            repeat ($urandom_range(3)) step();
            bus.cmd_snt = 1'b1; step(); bus.cmd_snt = 1'b0;
            repeat (rdly < 0 ? int'($urandom_range(5)) : rdly) step();
            do nb = 8'($urandom); while (nb == 8'hA5);
            bus.resp_rdy = 1'b1; bus.resp = (k == nak_at) ? nb : 8'hA5; step(); bus.resp_rdy = 1'b0;
            k++;
         end else step();
         guard++;
      end
      chk("run_finished", {31'd0, o_done | o_err}, 1);
      nak   = nak_at >= 0 && nak_at < exp_q.size();
      n_exp = nak ? nak_at + 1 : exp_q.size();
      acked = nak ? nak_at - int'(cal) : q_model.size();
      if (acked < 0) acked = 0;
      chk("sent_n", sent.size() - n0, n_exp);
      for (int i = 0; i < n_exp && n0 + i < sent.size(); i++) chk($sformatf("sent_cmd%0d", i), sent[n0 + i], exp_q[i]);
      chk("run_done", {31'd0, o_done}, {31'd0, !nak});
      chk("run_err", {31'd0, o_err}, {31'd0, nak});
      chk("run_code", {30'd0, o_err_code}, nak ? 1 : 0);
      chk("run_idx", {27'd0, o_cmd_idx}, acked);
      chk("run_busy", {31'd0, o_busy}, 0);
   endtask
   initial begin
      int n0, n, nak;
      bit cal;
      bus.cmd_snt = 1'b0; bus.resp_rdy = 1'b0; bus.resp = 8'h00;
      step(); step();
      rst = 1'b0;
      chk("rst_cmd", {16'd0, bus.cmd}, 0);
      chk("rst_snd", {31'd0, bus.snd_cmd}, 0);
      chk("rst_busy", {31'd0, o_busy}, 0);
      chk("rst_done", {31'd0, o_done}, 0);
      chk("rst_err", {31'd0, o_err}, 0);
      chk("rst_code", {30'd0, o_err_code}, 0);
      chk("rst_idx", {27'd0, o_cmd_idx}, 0);
      chk("rst_count", {27'd0, o_count}, 0);
      tv.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'd0});
      tv.push_back('{1'b1, 16'h1111, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 2'd0});
      tv.push_back('{1'b1, 16'h2222, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 2'd0});
      tv.push_back('{1'b1, 16'h3333, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 2'd0});
      tv.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 2'd0});
      tv.push_back('{1'b1, 16'h4444, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 2'd0});
      tv.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 2'd0});
      for (int i = 1; i <= 16; i++) tv.push_back('{1'b1, 16'(16'hA000 + i), 1'b0, 1'b0, 5'(i), 1'b1, 1'b0, 2'd0});
      tv.push_back('{1'b1, 16'hBEEF, 1'b0, 1'b0, 5'd16, 1'b0, 1'b1, 2'd3});
      tv.push_back('{1'b1, 16'hCAFE, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 2'd3});
      tv.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 2'd0});
      n0 = sent.size();
      foreach (tv[i]) begin
         i_wr_en = tv[i].wr; i_wr_cmd = tv[i].d; i_clr = tv[i].clr; i_start = tv[i].st;
         step();
         i_wr_en = 1'b0; i_clr = 1'b0; i_start = 1'b0;
         chk($sformatf("tv%0d_count", i), {27'd0, o_count}, {27'd0, tv[i].cnt});
         chk($sformatf("tv%0d_done", i), {31'd0, o_done}, {31'd0, tv[i].done});
         chk($sformatf("tv%0d_err", i), {31'd0, o_err}, {31'd0, tv[i].err});
         chk($sformatf("tv%0d_code", i), {30'd0, o_err_code}, {30'd0, tv[i].code});
         chk($sformatf("tv%0d_busy", i), {31'd0, o_busy}, 0);
      end
      chk("tv_no_snd", sent.size() - n0, 0);
      q_model.delete();
      wr(16'h43F3);
      run(1'b1, -1, -1);
      clr(); wr(16'h42D2); wr(16'h4002); wr(16'h47F1);
      run(1'b0, -1, -1);
      run(1'b0, 1, -1);
      n0 = sent.size();
      repeat (10) step();
      chk("nak_no_more_snd", sent.size() - n0, 0);
      run(1'b0, -1, -1);
      run(1'b0, -1, 99);
      i_start = 1'b1; step(); i_start = 1'b0;
      wait_snd();
      bus.cmd_snt = 1'b1; step(); bus.cmd_snt = 1'b0;
      repeat (99) step();
      chk("tmo_not_yet", {31'd0, o_err}, 0);
      chk("tmo_busy_99", {31'd0, o_busy}, 1);
      step();
      chk("tmo_err", {31'd0, o_err}, 1);
      chk("tmo_code", {30'd0, o_err_code}, 2);
      chk("tmo_idx", {27'd0, o_cmd_idx}, 0);
      i_start = 1'b1; step(); i_start = 1'b0;
      wait_snd();
      bus.cmd_snt = 1'b1; step(); bus.cmd_snt = 1'b0;
      step(); step();
      i_abort = 1'b1; step(); i_abort = 1'b0;
      n0 = sent.size();
      chk("abort_busy", {31'd0, o_busy}, 0);
      chk("abort_done", {31'd0, o_done}, 0);
      chk("abort_err", {31'd0, o_err}, 0);
      chk("abort_code", {30'd0, o_err_code}, 0);
      chk("abort_snd", {31'd0, bus.snd_cmd}, 0);
      bus.resp_rdy = 1'b1; bus.resp = 8'hA5; step(); bus.resp_rdy = 1'b0;
      repeat (5) step();
      chk("abort_late_busy", {31'd0, o_busy}, 0);
      chk("abort_late_done", {31'd0, o_done}, 0);
      chk("abort_late_idx", {27'd0, o_cmd_idx}, 0);
      chk("abort_count", {27'd0, o_count}, 3);
      chk("abort_no_snd", sent.size() - n0, 0);
      run(1'b1, -1, -1);
      i_start = 1'b1; step(); i_start = 1'b0;
      wait_snd();
      bus.cmd_snt = 1'b1; step(); bus.cmd_snt = 1'b0;
      rst = 1'b1; step(); rst = 1'b0;
      q_model.delete();
      chk("mrst_cmd", {16'd0, bus.cmd}, 0);
      chk("mrst_snd", {31'd0, bus.snd_cmd}, 0);
      chk("mrst_busy", {31'd0, o_busy}, 0);
      chk("mrst_done", {31'd0, o_done}, 0);
      chk("mrst_err", {31'd0, o_err}, 0);
      chk("mrst_code", {30'd0, o_err_code}, 0);
      chk("mrst_idx", {27'd0, o_cmd_idx}, 0);
      chk("mrst_count", {27'd0, o_count}, 0);
      for (int it = 0; it < 25; it++) begin
         clr();
         n = $urandom_range(16);
         for (int j = 0; j < n; j++) wr(16'($urandom));
         cal = 1'($urandom_range(1));
         nak = ($urandom_range(3) == 0 && n + int'(cal) > 0) ? int'($urandom_range(n + int'(cal) - 1)) : -1;
         run(cal, nak, -1);
         chk("rnd_count", {27'd0, o_count}, n);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
